// File: rtl/life_gen_sequencer.sv
// rtl/life_gen_sequencer.sv - Game of Life generation sequencer: frame-synchronous sweeps over ping-pong cell buffers

module life_gen_sequencer #(
  parameter int COLS     = 64,
  parameter int ROWS     = 48,
  parameter int RATE_DIV = 1600,
  parameter int GEN_W    = 16
) (
  input  logic             clock_50,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             load,
  input  logic             frame_start,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic [11:0]      upd_addr,
  output logic [5:0]       upd_col,
  output logic [5:0]       upd_row,
  output logic             load_mode,
  output logic             buf_sel,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count
);

  localparam int              DIV_W     = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [11:0]     LAST_ADDR = 12'(COLS * ROWS - 1);
  localparam logic [5:0]      LAST_COL  = 6'(COLS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SWEEP, SWAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             gen_pend;
  logic             load_pend;
  logic             div_tick;
  logic             gen_req;
  logic             gen_any;
  logic             load_any;

  // Requests arriving this cycle count as pending so a coincident frame_start is not lost.
  always_comb begin
    div_tick = run && (div_cnt == DIV_LAST);
    gen_req  = div_tick || (step && !run);
    gen_any  = gen_pend || gen_req;
    load_any = load_pend || load;
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!run || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gen_pend  <= 1'b0;
      load_pend <= 1'b0;
      upd_valid <= 1'b0;
      upd_addr  <= '0;
      upd_col   <= '0;
      upd_row   <= '0;
      load_mode <= 1'b0;
      buf_sel   <= 1'b0;
      busy      <= 1'b0;
      gen_done  <= 1'b0;
      gen_count <= '0;
    end else begin
      gen_done <= 1'b0;
      if (gen_req) gen_pend  <= 1'b1;
      if (load)    load_pend <= 1'b1;

      case (state)
        IDLE, ARMED: begin
          if (frame_start && (gen_any || load_any)) begin
            state     <= SWEEP;
            upd_valid <= 1'b1;
            busy      <= 1'b1;
            // Preset load takes priority; the other request stays queued.
            if (load_any) begin
              load_mode <= 1'b1;
              load_pend <= 1'b0;
            end else begin
              load_mode <= 1'b0;
              gen_pend  <= 1'b0;
            end
          end else if (gen_any || load_any) begin
            state <= ARMED;
          end
        end

        SWEEP: begin
          if (upd_ready) begin
            if (upd_addr == LAST_ADDR) begin
              state     <= SWAP;
              upd_valid <= 1'b0;
              buf_sel   <= ~buf_sel;
              gen_done  <= 1'b1;
              gen_count <= load_mode ? '0 : gen_count + 1'b1;
              upd_addr  <= '0;
              upd_col   <= '0;
              upd_row   <= '0;
            end else begin
              upd_addr <= upd_addr + 12'd1;
              if (upd_col == LAST_COL) begin
                upd_col <= '0;
                upd_row <= upd_row + 6'd1;
              end else begin
                upd_col <= upd_col + 6'd1;
              end
            end
          end
        end

        SWAP: begin
          busy      <= 1'b0;
          load_mode <= 1'b0;
          state     <= (gen_any || load_any) ? ARMED : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb/tb_life_gen_sequencer.sv - Directed bench with transaction-level sweep model for life_gen_sequencer

module tb_life_gen_sequencer;

  localparam int COLS     = 64;
  localparam int ROWS     = 48;
  localparam int CELLS    = COLS * ROWS;
  localparam int RATE_DIV = 8;
  localparam int GEN_W    = 3;

  logic             clock_50;
  logic             reset_n;
  logic             run;
  logic             step;
  logic             load;
  logic             frame_start;
  logic             upd_ready;
  logic             upd_valid;
  logic [11:0]      upd_addr;
  logic [5:0]       upd_col;
  logic [5:0]       upd_row;
  logic             load_mode;
  logic             buf_sel;
  logic             busy;
  logic             gen_done;
  logic [GEN_W-1:0] gen_count;

  logic rand_mode;
  logic rnd_bit;

  int dir_tests;
  int dir_fails;
  int mon_tests;
  int mon_fails;

  // Expected sweep kinds in order: 1 = preset load, 0 = generation.
  logic exp_modes [0:63];
  int   wr_ptr;
  int   rd_ptr;

  int   exp_idx;
  logic in_sweep;
  logic cur_mode;
  logic exp_buf;
  int   exp_count;
  int   done_seen;

  life_gen_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .RATE_DIV(RATE_DIV), .GEN_W(GEN_W)
  ) dut (
    .clock_50(clock_50), .reset_n(reset_n), .run(run), .step(step), .load(load),
    .frame_start(frame_start), .upd_ready(upd_ready), .upd_valid(upd_valid),
    .upd_addr(upd_addr), .upd_col(upd_col), .upd_row(upd_row), .load_mode(load_mode),
    .buf_sel(buf_sel), .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  assign upd_ready = rand_mode ? rnd_bit : 1'b1;

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clock_50);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // Sweep model: every valid cycle must present the next unvisited cell, and each
  // completed sweep must cover all cells, toggle the display buffer and update the count.
  always @(negedge clock_50) begin
    if (!reset_n) begin
      exp_idx   = 0;
      in_sweep  = 1'b0;
      exp_buf   = 1'b0;
      exp_count = 0;
    end else begin
      if (upd_valid) begin
        if (!in_sweep) begin
          mon_tests++;
          if (rd_ptr >= wr_ptr) begin
            mon_fails++;
            $display("FAIL unexpected_sweep: sweep started, expected sweeps queued %0d", wr_ptr - rd_ptr);
            cur_mode = 1'b0;
          end else begin
            cur_mode = exp_modes[rd_ptr];
            rd_ptr++;
          end
          in_sweep = 1'b1;
        end
        mon_tests++;
        if (int'(upd_addr) != exp_idx || int'(upd_col) != exp_idx % COLS ||
            int'(upd_row) != exp_idx / COLS || load_mode != cur_mode || busy != 1'b1) begin
          mon_fails++;
          $display("FAIL sweep_cell: addr=%0d col=%0d row=%0d load_mode=%0d busy=%0d, required addr=%0d col=%0d row=%0d load_mode=%0d busy=1",
                   upd_addr, upd_col, upd_row, load_mode, busy,
                   exp_idx, exp_idx % COLS, exp_idx / COLS, cur_mode);
        end
        if (upd_ready) exp_idx++;
      end
      if (gen_done) begin
        exp_buf   = ~exp_buf;
        exp_count = cur_mode ? 0 : (exp_count + 1) % (1 << GEN_W);
        mon_tests++;
        if (exp_idx != CELLS || upd_valid || !busy || buf_sel != exp_buf ||
            int'(gen_count) != exp_count) begin
          mon_fails++;
          $display("FAIL swap: cells=%0d valid=%0d busy=%0d buf_sel=%0d gen_count=%0d, required cells=%0d valid=0 busy=1 buf_sel=%0d gen_count=%0d",
                   exp_idx, upd_valid, busy, buf_sel, gen_count, CELLS, exp_buf, exp_count);
        end
        exp_idx  = 0;
        in_sweep = 1'b0;
        done_seen++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_50);
      #1;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    dir_tests++;
    if (act != req) begin
      dir_fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_sweep(input logic mode);
    exp_modes[wr_ptr] = mode;
    wr_ptr++;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(1); step = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1; tick(1); load = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick(1);
      if (gen_done) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, upd_valid, 0);
    chk({name, "_addr"}, {upd_addr, upd_col, upd_row}, 0);
    chk({name, "_load_mode"}, load_mode, 0);
    chk({name, "_buf_sel"}, buf_sel, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_gen_done"}, gen_done, 0);
    chk({name, "_gen_count"}, gen_count, 0);
  endtask

  initial begin
    int n;
    bit hit;
    dir_tests = 0; dir_fails = 0; mon_tests = 0; mon_fails = 0;
    wr_ptr = 0; rd_ptr = 0; done_seen = 0;
    exp_idx = 0; in_sweep = 1'b0; cur_mode = 1'b0; exp_buf = 1'b0; exp_count = 0;
    reset_n = 1'b0; run = 1'b0; step = 1'b0; load = 1'b0; frame_start = 1'b0;
    rand_mode = 1'b0;

    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick(2);

    // Single step, frame_start ten cycles later, full-rate sweep.
    expect_sweep(1'b0);
    pulse_step();
    tick(9);
    chk("armed_not_busy", busy, 0);
    frame_start = 1'b1;
    chk("valid_before_frame", upd_valid, 0);
    tick(1);
    frame_start = 1'b0;
    chk("valid_after_frame", upd_valid, 1);
    chk("first_addr", upd_addr, 0);
    tick(64);
    chk("addr_64", upd_addr, 64);
    chk("col_at_64", upd_col, 0);
    chk("row_at_64", upd_row, 1);
    n = 64;
    hit = 0;
    while (n < 4000 && !hit) begin
      tick(1);
      n++;
      if (gen_done) hit = 1;
    end
    chk("sweep_cycles", n, 3072);
    chk("swap_buf_sel", buf_sel, 1);
    chk("swap_gen_count", gen_count, 1);
    chk("swap_busy", busy, 1);
    tick(1);
    chk("idle_busy", busy, 0);
    chk("idle_gen_done", gen_done, 0);
    chk("single_gen_done", done_seen, 1);

    // Free-run at RATE_DIV=8: many ticks per frame merge into one sweep per frame_start.
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_sweep(1'b0);
      tick(4999);
      pulse_frame();
    end
    wait_done(4000, "freerun_done");
    chk("freerun_gen_count", gen_count, 4);
    chk("freerun_buf_sel", buf_sel, 0);
    run = 1'b0;
    tick(5);

    // Load and step queued while armed: load sweep first, then generation sweep.
    expect_sweep(1'b1);
    expect_sweep(1'b0);
    pulse_load();
    pulse_step();
    tick(3);
    pulse_frame();
    chk("load_sweep_mode", load_mode, 1);
    wait_done(4000, "load_done");
    chk("load_gen_count", gen_count, 0);
    tick(10);
    pulse_frame();
    chk("step_sweep_mode", load_mode, 0);
    wait_done(4000, "step_after_load_done");
    chk("step_after_load_count", gen_count, 1);
    tick(5);
    chk("no_extra_sweep", upd_valid, 0);

    // Backpressure from a randomly stalling update engine.
    rand_mode = 1'b1;
    expect_sweep(1'b0);
    pulse_step();
    tick(2);
    pulse_frame();
    wait_done(20000, "stall_done");
    chk("stall_gen_count", gen_count, 2);
    rand_mode = 1'b0;
    tick(3);

    // Reset in the middle of a sweep, then restart from address 0.
    expect_sweep(1'b0);
    pulse_step();
    tick(2);
    pulse_frame();
    hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      if (upd_addr == 12'd1500) hit = 1;
      else tick(1);
    end
    chk("reached_1500", hit, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    tick(2);
    reset_n = 1'b1;
    tick(2);
    expect_sweep(1'b0);
    pulse_step();
    tick(2);
    pulse_frame();
    chk("restart_valid", upd_valid, 1);
    chk("restart_addr", upd_addr, 0);
    wait_done(4000, "restart_done");
    chk("restart_gen_count", gen_count, 1);
    chk("restart_buf_sel", buf_sel, 1);

    // Generation counter wraps at 2^GEN_W.
    for (int g = 2; g <= 8; g++) begin
      expect_sweep(1'b0);
      tick(3);
      pulse_step();
      tick(1);
      pulse_frame();
      wait_done(4000, "wrap_done");
      chk("wrap_gen_count", gen_count, g % 8);
    end
    tick(5);
    chk("all_sweeps_seen", rd_ptr, wr_ptr);

    $display("[TB] %0d tests run, %0d failed", dir_tests + mon_tests, dir_fails + mon_fails);
    $finish;
  end

endmodule
